// File: rtl/rd_dma_engine_if.sv
// AXI4 read address + read data channels bundled for the read-DMA master.
// Latency: none (wires only).
// Backpressure: carried by arready/rready inside the bundle.
// Ports: master modport drives AR and rready; slave modport drives arready and the R channel.
interface rd_dma_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/rd_dma_engine.sv
// AXI4 read-DMA master: moves cfg_beats words from cfg_addr into the input buffer in
// INCR bursts of at most MAX_BURST beats that never cross a 4 KB page.
// Latency: AR one cycle after start; R beats pass to the buffer combinationally.
// Backpressure: buf_wready gates rready directly; a stalled beat stays on the R channel.
// Ports: clk/rstn (sync, active-low); cfg_addr/cfg_beats/start request; busy/done/err status;
//        buf_w* buffer write side; axi (rd_dma_engine_if.master) AR + R channels.
// Option: define RD_DMA_RESP_CHECK_EN to enable the rresp/rlast error flag (err tied 0 otherwise).
module rd_dma_engine #(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 256,
  parameter int                ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] ID       = 8'h80,
  parameter int                MAX_BURST  = 16,
  parameter int                LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_beats,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  output logic                  buf_wvalid,
  output logic                  buf_wlast,
  input  logic                  buf_wready,
  rd_dma_engine_if.master       axi
);

  localparam int BPB  = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);
  // common width for the three-way burst-length minimum
  localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BPB - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;  // beats of the transfer not yet consumed
  logic [8:0]            burst_q, burst_d;    // beats of the current burst not yet consumed
  logic [8:0]            blen_q, blen_d;      // length of the current burst, for address advance

  logic [12:0]   page_bytes;
  logic [CW-1:0] page_beats;
  logic [CW-1:0] cand;
  logic [8:0]    beats;
  logic          hit;
  logic          beat;

  // Burst size: min(remaining, MAX_BURST, beats left before the next 4 KB page).
  always_comb begin
    page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    page_beats = CW'(page_bytes >> SIZE);
    cand       = CW'(remain_q);
    if (CW'(MAX_BURST) < cand) cand = CW'(MAX_BURST);
    if (page_beats < cand)     cand = page_beats;
    beats      = cand[8:0];
  end

  assign axi.arid    = ID;
  assign axi.arsize  = 3'(SIZE);
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == ADDR);
  assign axi.araddr  = addr_q;
  // arlen is forced to 0 outside ADDR so the idle/reset value is clean
  assign axi.arlen   = (state_q == ADDR) ? 8'(beats - 9'd1) : 8'd0;

  // Beats carrying a foreign ID are left on the bus untouched.
  assign hit        = (state_q == DATA) && axi.rvalid && (axi.rid == ID);
  assign axi.rready = hit && buf_wready;
  assign beat       = hit && buf_wready;
  assign buf_wvalid = hit;
  assign buf_wdata  = axi.rdata;
  assign buf_wlast  = hit && (burst_q == 9'd1) && (remain_q == LEN_WIDTH'(1));

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    burst_d  = burst_q;
    blen_d   = blen_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_beats != '0) begin
            addr_d   = cfg_addr & ~LOW_MASK;
            remain_d = cfg_beats;
            state_d  = ADDR;
          end else begin
            state_d  = DONE;
          end
        end
      end
      ADDR: begin
        if (axi.arready) begin
          burst_d = beats;
          blen_d  = beats;
          state_d = DATA;
        end
      end
      DATA: begin
        // the internal counter alone decides where a burst ends; rlast is not trusted
        if (beat) begin
          burst_d  = burst_q - 9'd1;
          remain_d = remain_q - LEN_WIDTH'(1);
          if (burst_q == 9'd1) begin
            if (remain_q == LEN_WIDTH'(1)) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + (ADDR_WIDTH'(blen_q) << SIZE);
              state_d = ADDR;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      burst_q  <= '0;
      blen_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      burst_q  <= burst_d;
      blen_q   <= blen_d;
    end
  end

`ifdef RD_DMA_RESP_CHECK_EN
  logic err_q, err_d;

  // Sticky until the next accepted start; the transfer itself is never aborted.
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = 1'b0;
    end else if (beat && ((axi.rresp != 2'b00) || (axi.rlast != (burst_q == 9'd1)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{axi.rresp, axi.rlast};
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_rd_dma_engine.sv
// Directed bench for rd_dma_engine: an in-bench AXI slave returns address-tagged data,
// and each transfer is checked against hand-computed AR sequences and beat counts.
// Latency/backpressure are checked through recorded cycle indices and rready/buf_wready.
module tb_rd_dma_engine;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 8;
  localparam logic [7:0] DMA_ID = 8'h80;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_beats = '0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [DW-1:0] buf_wdata;
  logic          buf_wvalid, buf_wlast;
  logic          buf_wready = 1'b1;

  rd_dma_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  rd_dma_engine dut (
    .clk(clk), .rstn(rstn), .cfg_addr(cfg_addr), .cfg_beats(cfg_beats), .start(start),
    .busy(busy), .done(done), .err(err), .buf_wdata(buf_wdata), .buf_wvalid(buf_wvalid),
    .buf_wlast(buf_wlast), .buf_wready(buf_wready), .axi(axi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // run log
  logic [31:0] ar_a[$];
  int          ar_l[$];
  int n_wr, n_data_bad, n_wlast, wlast_idx, n_done, done_cyc, last_cyc, rr_viol;
  logic err_seen, busy_at_done;

  // slave state
  logic        r_active;
  logic [31:0] r_addr;
  int          r_len, r_idx;

  task automatic run_xfer(input logic [31:0] addr, input int beats, input bit toggle,
                          input int bad_beat, input int stray_at, input int abort_after);
    logic [31:0] addr_al;
    addr_al = addr & ~32'h1F;
    ar_a.delete(); ar_l.delete();
    n_wr = 0; n_data_bad = 0; n_wlast = 0; wlast_idx = -1; n_done = 0;
    done_cyc = -1; last_cyc = -1; rr_viol = 0; err_seen = 1'b0; busy_at_done = 1'b0;
    r_active = 1'b0; r_addr = '0; r_len = 0; r_idx = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // drive this cycle's inputs
      start       = (cyc == 0) || (cyc == stray_at);
      cfg_addr    = (cyc == 0) ? addr : 32'h5000;
      cfg_beats   = (cyc == 0) ? 16'(beats) : 16'd3;
      buf_wready  = toggle ? (cyc % 2 == 1) : 1'b1;
      axi.arready = (cyc % 2 == 0);
      axi.rvalid  = r_active;
      axi.rid     = DMA_ID;
      axi.rdata   = {8{r_addr + 32'(r_idx * 32)}};
      axi.rresp   = (n_wr + 1 == bad_beat) ? 2'b10 : 2'b00;
      axi.rlast   = (r_idx == r_len);
      #1;
      if (axi.rready && !buf_wready) rr_viol++;
      if (axi.rvalid && axi.rready) begin
        if (!buf_wvalid || buf_wdata !== {8{addr_al + 32'(n_wr * 32)}}) n_data_bad++;
        if (buf_wlast) begin
          n_wlast++; wlast_idx = n_wr; last_cyc = cyc;
        end
        n_wr++;
        r_idx++;
        if (r_idx > r_len) r_active = 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        ar_a.push_back(axi.araddr);
        ar_l.push_back(int'(axi.arlen));
        r_addr = axi.araddr; r_len = int'(axi.arlen); r_idx = 0; r_active = 1'b1;
      end
      if (err) err_seen = 1'b1;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = busy;
        end
      end
      if (abort_after >= 0 && n_wr >= abort_after) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_arlen", axi.arlen, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wvalid", buf_wvalid, 0);
    chk("arid", axi.arid, 8'h80);
    chk("arsize", axi.arsize, 3'd5);
    chk("arburst", axi.arburst, 2'b01);
    rstn = 1'b1;

    // single full burst
    run_xfer(32'h1000, 16, 1'b0, 0, -1, -1);
    chk("t1_ar_cnt", ar_a.size(), 1);
    chk("t1_ar_addr", ar_a[0], 32'h1000);
    chk("t1_ar_len", ar_l[0], 15);
    chk("t1_writes", n_wr, 16);
    chk("t1_data_bad", n_data_bad, 0);
    chk("t1_wlast_idx", wlast_idx, 15);
    chk("t1_wlast_cnt", n_wlast, 1);
    chk("t1_done_lat", done_cyc, last_cyc + 1);
    chk("t1_done_cnt", n_done, 1);

    // three bursts, with a stray start mid-transfer that must be ignored
    run_xfer(32'h1000, 40, 1'b0, 0, 8, -1);
    chk("t2_ar_cnt", ar_a.size(), 3);
    chk("t2_ar0_addr", ar_a[0], 32'h1000);
    chk("t2_ar1_addr", ar_a[1], 32'h1200);
    chk("t2_ar2_addr", ar_a[2], 32'h1400);
    chk("t2_ar0_len", ar_l[0], 15);
    chk("t2_ar1_len", ar_l[1], 15);
    chk("t2_ar2_len", ar_l[2], 7);
    chk("t2_writes", n_wr, 40);
    chk("t2_data_bad", n_data_bad, 0);
    chk("t2_wlast_idx", wlast_idx, 39);
    chk("t2_done_cnt", n_done, 1);

    // 4 KB split: 128 bytes left in the page = 4 beats
    run_xfer(32'h1F80, 16, 1'b0, 0, -1, -1);
    chk("t3_ar_cnt", ar_a.size(), 2);
    chk("t3_ar0_addr", ar_a[0], 32'h1F80);
    chk("t3_ar0_len", ar_l[0], 3);
    chk("t3_ar1_addr", ar_a[1], 32'h2000);
    chk("t3_ar1_len", ar_l[1], 11);
    chk("t3_writes", n_wr, 16);
    chk("t3_data_bad", n_data_bad, 0);

    // buffer backpressure toggling every cycle
    run_xfer(32'h0040, 8, 1'b1, 0, -1, -1);
    chk("t4_ar_len", ar_l[0], 7);
    chk("t4_writes", n_wr, 8);
    chk("t4_data_bad", n_data_bad, 0);
    chk("t4_rready_viol", rr_viol, 0);
    chk("t4_wlast_idx", wlast_idx, 7);

    // zero-length transfer: straight to DONE, no AR
    run_xfer(32'h1000, 0, 1'b0, 0, -1, -1);
    chk("t5_ar_cnt", ar_a.size(), 0);
    chk("t5_done_cyc", done_cyc, 1);
    chk("t5_done_cnt", n_done, 1);
    chk("t5_busy", busy_at_done, 1);

    // error response on beat 3
    run_xfer(32'h0000, 8, 1'b0, 3, -1, -1);
    chk("t6_writes", n_wr, 8);
    chk("t6_done_cnt", n_done, 1);
`ifdef RD_DMA_RESP_CHECK_EN
    chk("t6_err_seen", err_seen, 1);
    chk("t6_err_held", err, 1);
`else
    chk("t6_err_seen", err_seen, 0);
    chk("t6_err_held", err, 0);
`endif

    // reset during DATA; the new start also clears err
    run_xfer(32'h3000, 16, 1'b0, 0, -1, 5);
    chk("t7_err_clr", err, 0);
    chk("t7_pre_busy", busy, 1);
    rstn = 1'b0;
    @(posedge clk); #2;
    chk("t7_rst_arvalid", axi.arvalid, 0);
    chk("t7_rst_rready", axi.rready, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_wvalid", buf_wvalid, 0);
    rstn = 1'b1;
    axi.rvalid = 1'b0;
    // restart with an unaligned address; low 5 bits must be dropped
    run_xfer(32'h301F, 4, 1'b0, 0, -1, -1);
    chk("t8_ar_addr", ar_a[0], 32'h3000);
    chk("t8_ar_len", ar_l[0], 3);
    chk("t8_writes", n_wr, 4);
    chk("t8_data_bad", n_data_bad, 0);
    chk("t8_done_cnt", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
